// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the MEM-stage controller:
//                FSM state encoding, default data width, register-address
//                width and the all-zero MEM/WB control bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_DATA_W_DEFAULT = 32;
    localparam int c_REG_ADDR_W     = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Control half of the MEM/WB register; the data fields are DATA_W wide
    // and are zeroed separately by the owner of the register.
    typedef struct packed {
        logic                    jal;
        logic                    reg_write;
        logic                    mem_to_reg;
        logic [c_REG_ADDR_W-1:0] write_register;
    } memwb_ctrl_t;

    localparam memwb_ctrl_t c_MEMWB_BUBBLE = '0;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_timeout_counter
//  Description : 8-bit BUSY-cycle counter. Cleared by i_clear, advanced by
//                i_enable. o_terminal is high while the count equals LIMIT-1,
//                i.e. in the LIMIT-th counted cycle, so that cycle can be the
//                one that aborts the transaction.
//  Ports       : clk, reset (async, active-low), i_clear, i_enable,
//                o_terminal
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_terminal = (r_count == 8'(LIMIT - 1));

endmodule : mem_timeout_counter
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : MEM-stage controller of the pipelined MIPS core. Issues
//                load/store transactions to a variable-latency data memory
//                over a req/ack handshake, stalls upstream stages while a
//                transaction is outstanding, and acts as the MEM/WB register.
//  Ports       : clk, reset (async, active-low)
//                in_Ctrl_* / in_Write_Register / in_ALU_Result /
//                in_Write_Data  : EX/MEM fields
//                mem_req/mem_we/mem_addr/mem_wdata : registered request
//                mem_ack/mem_rdata                  : memory completion
//                stall          : combinational upstream freeze
//                out_*          : MEM/WB fields to write-back
//                mem_error      : sticky timeout flag
//  Config      : `define MEM_TIMEOUT_EN to abort transactions after
//                TIMEOUT_CYCLES BUSY cycles; otherwise BUSY waits forever
//                and mem_error is tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W         = c_DATA_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_Ctrl_Jal,
    input  logic                    in_Ctrl_RegWrite,
    input  logic                    in_Ctrl_MemToReg,
    input  logic                    in_Ctrl_MemRead,
    input  logic                    in_Ctrl_MemWrite,
    input  logic [c_REG_ADDR_W-1:0] in_Write_Register,
    input  logic [DATA_W-1:0]       in_ALU_Result,
    input  logic [DATA_W-1:0]       in_Write_Data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    stall,
    output logic                    out_Ctrl_Jal,
    output logic                    out_Ctrl_RegWrite,
    output logic                    out_Ctrl_MemToReg,
    output logic [c_REG_ADDR_W-1:0] out_Write_Register,
    output logic [DATA_W-1:0]       out_ALU_Result,
    output logic [DATA_W-1:0]       out_Read_Data,
    output logic                    mem_error
);

    state_t             r_state,     w_state_nxt;
    logic               r_mem_req,   w_mem_req_nxt;
    logic               r_mem_we,    w_mem_we_nxt;
    logic [DATA_W-1:0]  r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]  r_mem_wdata, w_mem_wdata_nxt;
    memwb_ctrl_t        r_out_ctrl,  w_out_ctrl_nxt;
    logic [DATA_W-1:0]  r_out_alu,   w_out_alu_nxt;
    logic [DATA_W-1:0]  r_out_rdata, w_out_rdata_nxt;
    logic               w_stall;
    logic               w_mem_op;
    logic               w_timeout;
    memwb_ctrl_t        w_in_ctrl;

    assign w_mem_op  = in_Ctrl_MemRead | in_Ctrl_MemWrite;
    assign w_in_ctrl = {in_Ctrl_Jal, in_Ctrl_RegWrite, in_Ctrl_MemToReg,
                        in_Write_Register};

`ifdef MEM_TIMEOUT_EN
    logic r_mem_error;
    logic w_terminal;

    // Cleared during the issue cycle so counting starts fresh in BUSY.
    mem_timeout_counter #(
        .LIMIT      (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (r_state == IDLE),
        .i_enable   ((r_state == BUSY) && !mem_ack),
        .o_terminal (w_terminal)
    );

    // An ack in the terminal cycle completes normally.
    assign w_timeout = (r_state == BUSY) && !mem_ack && w_terminal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_error <= 1'b0;
        end else if (w_timeout) begin
            r_mem_error <= 1'b1;
        end
    end

    assign mem_error = r_mem_error;
`else
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign mem_error        = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_out_ctrl  <= c_MEMWB_BUBBLE;
            r_out_alu   <= '0;
            r_out_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_out_ctrl  <= w_out_ctrl_nxt;
            r_out_alu   <= w_out_alu_nxt;
            r_out_rdata <= w_out_rdata_nxt;
        end
    end

    // Next-state and next-output logic. Default is "hold request, load bubble".
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_out_ctrl_nxt  = c_MEMWB_BUBBLE;
        w_out_alu_nxt   = '0;
        w_out_rdata_nxt = '0;
        w_stall         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    // Store wins when both read and write are flagged.
                    w_stall         = 1'b1;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = in_Ctrl_MemWrite;
                    w_mem_addr_nxt  = in_ALU_Result;
                    w_mem_wdata_nxt = in_Write_Data;
                    w_state_nxt     = BUSY;
                end else begin
                    w_out_ctrl_nxt  = w_in_ctrl;
                    w_out_alu_nxt   = in_ALU_Result;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    w_out_ctrl_nxt  = w_in_ctrl;
                    w_out_alu_nxt   = in_ALU_Result;
                    w_out_rdata_nxt = r_mem_we ? '0 : mem_rdata;
                    w_mem_req_nxt   = 1'b0;
                    w_state_nxt     = IDLE;
                end else if (w_timeout) begin
                    // Abandoned load must not write a garbage register.
                    w_out_ctrl_nxt           = w_in_ctrl;
                    w_out_ctrl_nxt.reg_write = 1'b0;
                    w_out_alu_nxt            = in_ALU_Result;
                    w_mem_req_nxt            = 1'b0;
                    w_state_nxt              = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Stall must stay low while reset is held, whatever the inputs show.
    assign stall              = w_stall & reset;

    assign mem_req            = r_mem_req;
    assign mem_we             = r_mem_we;
    assign mem_addr           = r_mem_addr;
    assign mem_wdata          = r_mem_wdata;
    assign out_Ctrl_Jal       = r_out_ctrl.jal;
    assign out_Ctrl_RegWrite  = r_out_ctrl.reg_write;
    assign out_Ctrl_MemToReg  = r_out_ctrl.mem_to_reg;
    assign out_Write_Register = r_out_ctrl.write_register;
    assign out_ALU_Result     = r_out_alu;
    assign out_Read_Data      = r_out_rdata;

endmodule : mem_access_ctrl
`default_nettype wire
